cache_fill_arbiter: RTL and testbench
=====================================

# cache_fill_arbiter

Shares the single main-memory port between the instruction-cache and data-cache miss paths of the five-stage pipeline. It also carries data-side write-through stores. On a miss it takes a 16-byte block address, issues eight pipelined word reads, and steers the returning words into the granted cache's data array. It then writes the tag and pulses a done strobe so the stalled stage can retry. It sits beside the pipeline, between the two caches and main memory.

## Interface
Parameters:
- MEM_LAT, 4, cycles from a sampled mem_en read to its mem_rvalid word
- WORDS, 8, 16-bit words per block (fixed 8 in this revision; 3-bit word index)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_miss  in  1  I-cache miss request (level, held until i_done)
- i_addr  in  16  I-side miss byte address
- d_miss  in  1  D-cache miss request (level, held until d_done)
- d_addr  in  16  D-side miss byte address
- d_wr  in  1  D-side write-through store request (level, held until d_wr_ack)
- d_wr_addr  in  16  store byte address
- d_wr_data  in  16  store data
- d_wr_ack  out  1  store accepted this cycle
- mem_en  out  1  memory access strobe
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  returning read word
- mem_rvalid  in  1  mem_rdata valid, in issue order
- fill_sel  out  1  0 = I-cache, 1 = D-cache target
- fill_we  out  1  write fill_data into target data array
- fill_word  out  3  word index within block
- fill_data  out  16  equals mem_rdata
- fill_tag_we  out  1  write tag/valid for fill block
- i_done  out  1  one-cycle pulse, I fill complete
- d_done  out  1  one-cycle pulse, D fill complete

## Operation
- States: IDLE, FILL, DONE.
- IDLE arbitration uses fixed priority d_wr > d_miss > i_miss.
  - d_wr: drive mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data and d_wr_ack=1 combinationally; stay in IDLE.
  - d_miss or i_miss: latch block = addr[15:4] and sel, clear issue_cnt and recv_cnt, go to FILL. No memory access occurs in the grant cycle.
- FILL issue side:
  - While issue_cnt < WORDS: mem_en=1, mem_wr=0, mem_addr={block,issue_cnt[2:0],1'b0}; issue_cnt++.
- FILL receive side:
  - On mem_rvalid: fill_we=1, fill_word=recv_cnt, fill_data=mem_rdata; recv_cnt++.
  - On recv_cnt==WORDS-1 with mem_rvalid: also fill_tag_we=1; go to DONE.
- DONE: pulse i_done or d_done per latched sel, go to IDLE.
- Granted request is latched. Dropping i_miss/d_miss mid-fill does not abort the fill.
- d_wr during FILL/DONE is not acked; it waits.
- mem_rvalid outside FILL is ignored: no fill_we.
- fill_sel holds the latched sel in FILL/DONE and is 0 in IDLE.

## Timing
- Reset value of every output is 0; state is IDLE; counters are 0.
- Grant cycle is T. Reads issue T+1..T+8. Words return T+1+MEM_LAT..T+8+MEM_LAT (T+5..T+12 at default). done pulses at T+13. A new request can be granted at T+14.
- A store is acked in the same cycle it is seen in IDLE (zero added latency).
- Simultaneous d_miss and i_miss: D served first. I is granted on the first IDLE cycle after d_done.
- Reset asserted mid-FILL: immediate IDLE with outputs 0. Outstanding memory words arriving afterwards are dropped, and no tag is written.
- Word index wraps only within the 3-bit field. Block address bits are never incremented.

## Structure
- Shared package cache_pkg holds:
  - state enum (IDLE, FILL, DONE)
  - BLOCK_WORDS=8, OFFSET_BITS=4
  - SEL_I/SEL_D encodings
- The caches reuse these constants.
- One sub-module, fill_addr_gen, holds the issue counter and address formation. The FSM and receive counter stay in the top.

## Test plan
- Lone i_miss, i_addr=0x1236, MEM_LAT=4 -> reads 0x1230..0x123E on T+1..T+8; fill_we words 0..7 on T+5..T+12 with fill_sel=0; fill_tag_we at T+12; i_done at T+13.
- d_miss and i_miss same cycle -> D block filled and d_done at T+13; I grant at T+14, i_done at T+27.
- d_wr 0x0040/0xBEEF during a fill -> no ack until IDLE. Then a same-cycle write with d_wr_ack=1, mem_wr=1 and the given address/data. d_wr together with d_miss in IDLE -> store first.
- rst pulsed at T+7 of a fill -> all outputs 0 next edge. Stray mem_rvalid words give no fill_we; no done pulse.
- i_miss dropped at T+3 -> fill still completes; i_done at T+13.
- mem_rvalid asserted in IDLE -> fill_we stays 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-side definitions: fill FSM states, block geometry and target-cache encodings.
// Both cache models and the fill arbiter import this package.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  localparam int BLOCK_WORDS = 8;
  localparam int OFFSET_BITS = 4;
  localparam int ADDR_BITS   = 16;
  localparam int BLOCK_BITS  = ADDR_BITS - OFFSET_BITS;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/fill_addr_gen.sv
// Issue side of a block fill: counts the word reads sent to memory and forms their byte addresses.
// The block address is fixed for the whole fill; only the 3-bit word index advances.
module fill_addr_gen
  import cache_pkg::*;
#(
  parameter int WORDS = BLOCK_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  active,
  input  logic [BLOCK_BITS-1:0] block,
  output logic                  rd_en,
  output logic [ADDR_BITS-1:0]  rd_addr
);

  logic [3:0] issue_cnt_q;
  logic [3:0] issue_cnt_d;

  assign rd_en = active && (issue_cnt_q < 4'(WORDS));

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    if (start) begin
      issue_cnt_d = '0;
    end else if (rd_en) begin
      issue_cnt_d = issue_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
    end
  end

  // Address is held at zero between reads so the shared bus stays quiet.
  assign rd_addr = rd_en ? {block, issue_cnt_q[2:0], 1'b0} : '0;

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares the main-memory port between I-cache and D-cache miss fills and D-side write-through stores.
// Stores win in IDLE and complete in the cycle they are seen; misses run an 8-word pipelined block fill.
module cache_fill_arbiter
  import cache_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_addr,
  input  logic        d_miss,
  input  logic [15:0] d_addr,
  input  logic        d_wr,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        d_wr_ack,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        fill_sel,
  output logic        fill_we,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        fill_tag_we,
  output logic        i_done,
  output logic        d_done
);

  fill_state_e           state_q;
  logic                  sel_q;
  logic [BLOCK_BITS-1:0] block_q;
  logic [2:0]            recv_cnt_q;

  logic                  grant_sel_d;
  logic [BLOCK_BITS-1:0] grant_block_d;

  logic                  in_idle;
  logic                  in_fill;
  logic                  in_done;
  logic                  store_go;
  logic                  grant;
  logic                  rx;
  logic                  last_word;
  logic                  rd_en;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic                  rd_pipe_q [MEM_LAT];
  logic                  unused_addr_lsbs;

  assign in_idle = (state_q == ST_IDLE);
  assign in_fill = (state_q == ST_FILL);
  assign in_done = (state_q == ST_DONE);

  // A store is only visible outside reset so every output reads 0 while rst is held.
  assign store_go = in_idle && d_wr && !rst;
  assign grant    = in_idle && !d_wr && (d_miss || i_miss);

  assign grant_sel_d   = d_miss ? SEL_D : SEL_I;
  assign grant_block_d = d_miss ? d_addr[15:OFFSET_BITS] : i_addr[15:OFFSET_BITS];
  assign unused_addr_lsbs = ^{i_addr[OFFSET_BITS-1:0], d_addr[OFFSET_BITS-1:0]};

  fill_addr_gen #(
    .WORDS (WORDS)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .start   (grant),
    .active  (in_fill),
    .block   (block_q),
    .rd_en   (rd_en),
    .rd_addr (rd_addr)
  );

  // Tracks which cycles carry a word we actually asked for; words from reads issued
  // before a reset never line up with a set bit and are dropped.
  for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_rd_pipe
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_pipe_q[gi] <= 1'b0;
        end else begin
          rd_pipe_q[gi] <= rd_en;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_pipe_q[gi] <= 1'b0;
        end else begin
          rd_pipe_q[gi] <= rd_pipe_q[gi-1];
        end
      end
    end
  end

  assign rx        = in_fill && mem_rvalid && rd_pipe_q[MEM_LAT-1];
  assign last_word = rx && (recv_cnt_q == 3'(WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_I;
      block_q    <= '0;
      recv_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            sel_q      <= grant_sel_d;
            block_q    <= grant_block_d;
            recv_cnt_q <= '0;
            state_q    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (rx) begin
            recv_cnt_q <= recv_cnt_q + 3'd1;
          end
          if (last_word) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign d_wr_ack  = store_go;
  assign mem_en    = store_go || rd_en;
  assign mem_wr    = store_go;
  assign mem_addr  = store_go ? d_wr_addr : rd_addr;
  assign mem_wdata = store_go ? d_wr_data : '0;

  assign fill_sel    = !in_idle && sel_q;
  assign fill_we     = rx;
  assign fill_word   = rx ? recv_cnt_q : '0;
  assign fill_data   = rx ? mem_rdata : '0;
  assign fill_tag_we = last_word;
  assign i_done      = in_done && (sel_q == SEL_I);
  assign d_done      = in_done && (sel_q == SEL_D);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: IDLE vector table plus hand-written fill sequences
// against a fixed-latency memory model.
module tb_cache_fill_arbiter;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        i_miss;
  logic [15:0] i_addr;
  logic        d_miss;
  logic [15:0] d_addr;
  logic        d_wr;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic        d_wr_ack;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        fill_sel;
  logic        fill_we;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        fill_tag_we;
  logic        i_done;
  logic        d_done;

  int n_cmp = 0;
  int n_bad = 0;

  cache_fill_arbiter #(
    .MEM_LAT (LAT),
    .WORDS   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_miss      (i_miss),
    .i_addr      (i_addr),
    .d_miss      (d_miss),
    .d_addr      (d_addr),
    .d_wr        (d_wr),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .d_wr_ack    (d_wr_ack),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .fill_sel    (fill_sel),
    .fill_we     (fill_we),
    .fill_word   (fill_word),
    .fill_data   (fill_data),
    .fill_tag_we (fill_tag_we),
    .i_done      (i_done),
    .d_done      (d_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: a read sampled in cycle c returns its word in cycle c+LAT. Not reset,
  // so reads in flight across a DUT reset still come back.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  logic        pv [LAT];
  logic [15:0] pa [LAT];
  logic        man_rv;
  logic [15:0] man_data;

  initial begin
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pa[i] = 16'h0;
    end
  end

  always @(posedge clk) begin
    pv[0] <= mem_en && !mem_wr;
    pa[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end

  assign mem_rvalid = pv[LAT-1] | man_rv;
  assign mem_rdata  = pv[LAT-1] ? mem_word(pa[LAT-1]) : man_data;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, ".d_wr_ack"}, d_wr_ack, 1'b0);
    chk1({tag, ".mem_en"}, mem_en, 1'b0);
    chk1({tag, ".mem_wr"}, mem_wr, 1'b0);
    chk16({tag, ".mem_addr"}, mem_addr, 16'h0);
    chk16({tag, ".mem_wdata"}, mem_wdata, 16'h0);
    chk1({tag, ".fill_sel"}, fill_sel, 1'b0);
    chk1({tag, ".fill_we"}, fill_we, 1'b0);
    chk16({tag, ".fill_word"}, 16'(fill_word), 16'h0);
    chk16({tag, ".fill_data"}, fill_data, 16'h0);
    chk1({tag, ".fill_tag_we"}, fill_tag_we, 1'b0);
    chk1({tag, ".i_done"}, i_done, 1'b0);
    chk1({tag, ".d_done"}, d_done, 1'b0);
  endtask

  // Called at the negedge of grant cycle T; checks T+1..T+13. Drops the served miss at
  // drop_k and again on the done cycle; raises a store 0x0040/0xBEEF at wr_k.
  task automatic expect_fill(input logic sel, input logic [15:0] base,
                             input int drop_k, input int wr_k);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      chk1("fill.mem_en", mem_en, k <= 8);
      if (k <= 8) begin
        chk1("fill.mem_wr", mem_wr, 1'b0);
        chk16("fill.mem_addr", mem_addr, base + 16'(2 * (k - 1)));
      end
      chk1("fill.fill_we", fill_we, (k >= 5) && (k <= 12));
      if ((k >= 5) && (k <= 12)) begin
        chk16("fill.fill_word", 16'(fill_word), 16'(k - 5));
        chk16("fill.fill_data", fill_data, mem_word(base + 16'(2 * (k - 5))));
      end
      chk1("fill.fill_sel", fill_sel, sel);
      chk1("fill.tag_we", fill_tag_we, k == 12);
      chk1("fill.i_done", i_done, (k == 13) && !sel);
      chk1("fill.d_done", d_done, (k == 13) && sel);
      chk1("fill.d_wr_ack", d_wr_ack, 1'b0);
      if (k == wr_k) begin
        d_wr      = 1'b1;
        d_wr_addr = 16'h0040;
        d_wr_data = 16'hBEEF;
      end
      if ((k == drop_k) || (k == 13)) begin
        if (sel) d_miss = 1'b0;
        else     i_miss = 1'b0;
      end
    end
    $display("fill sel=%0d base=%h finished, compared=%0d mismatched=%0d", sel, base, n_cmp, n_bad);
  endtask

  typedef struct {
    logic        d_wr;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        d_miss;
    logic        i_miss;
    logic        rv;
    logic [15:0] rdata;
    logic        exp_en;
    logic        exp_wr;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    logic        exp_ack;
  } idle_vec_t;

  idle_vec_t vecs [6];

  initial begin
    // d_wr, addr, data, d_miss, i_miss, rvalid, rdata | en, wr, addr, wdata, ack
    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 16'h0040, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1};
    vecs[2] = '{1'b1, 16'hFFFE, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 16'h0001, 1'b1};
    vecs[3] = '{1'b1, 16'h1234, 16'hA5A5, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'hA5A5, 1'b1};
    vecs[4] = '{1'b1, 16'h0002, 16'h7FFF, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 16'h7FFF, 1'b1};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};

    rst = 1'b1;
    i_miss = 1'b0; i_addr = 16'h0;
    d_miss = 1'b0; d_addr = 16'h0;
    d_wr = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    man_rv = 1'b0; man_data = 16'h0;

    // Reset: outputs zero even with a store request pending.
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    $display("reset held with d_wr=1: outputs checked");
    d_wr = 1'b0;
    rst  = 1'b0;
    @(negedge clk);

    // IDLE vector table: stores, store-over-miss priority, stray rvalid.
    for (int v = 0; v < 6; v++) begin
      d_wr = vecs[v].d_wr; d_wr_addr = vecs[v].wa; d_wr_data = vecs[v].wd;
      d_miss = vecs[v].d_miss; i_miss = vecs[v].i_miss;
      man_rv = vecs[v].rv; man_data = vecs[v].rdata;
      #1;
      chk1("vec.mem_en", mem_en, vecs[v].exp_en);
      chk1("vec.mem_wr", mem_wr, vecs[v].exp_wr);
      chk16("vec.mem_addr", mem_addr, vecs[v].exp_addr);
      chk16("vec.mem_wdata", mem_wdata, vecs[v].exp_wdata);
      chk1("vec.d_wr_ack", d_wr_ack, vecs[v].exp_ack);
      chk1("vec.fill_we", fill_we, 1'b0);
      chk1("vec.fill_sel", fill_sel, 1'b0);
      chk1("vec.i_done", i_done, 1'b0);
      chk1("vec.d_done", d_done, 1'b0);
      $display("vec %0d: d_wr=%b addr=%h data=%h rv=%b -> en=%b wr=%b ack=%b",
               v, d_wr, d_wr_addr, d_wr_data, man_rv, mem_en, mem_wr, d_wr_ack);
      @(negedge clk);
    end
    d_wr = 1'b0; d_miss = 1'b0; i_miss = 1'b0; man_rv = 1'b0;
    @(negedge clk);

    // Lone I miss, offset inside block ignored.
    i_miss = 1'b1; i_addr = 16'h1236;
    #1 chk1("grant.mem_en", mem_en, 1'b0);
    expect_fill(1'b0, 16'h1230, -1, -1);
    @(negedge clk);
    chk1("post.i_done", i_done, 1'b0);
    chk1("post.mem_en", mem_en, 1'b0);

    // Simultaneous D and I: D first, I granted the first IDLE cycle after d_done.
    d_miss = 1'b1; d_addr = 16'h4008;
    i_miss = 1'b1; i_addr = 16'h00F2;
    expect_fill(1'b1, 16'h4000, -1, -1);
    @(negedge clk);
    chk1("igrant.mem_en", mem_en, 1'b0);
    chk1("igrant.fill_sel", fill_sel, 1'b0);
    expect_fill(1'b0, 16'h00F0, -1, -1);
    @(negedge clk);

    // Store raised mid-fill waits; I miss dropped at T+3 still completes.
    i_miss = 1'b1; i_addr = 16'hFFFA;
    expect_fill(1'b0, 16'hFFF0, 3, 2);
    @(negedge clk);
    chk1("wait_wr.ack", d_wr_ack, 1'b1);
    chk1("wait_wr.mem_en", mem_en, 1'b1);
    chk1("wait_wr.mem_wr", mem_wr, 1'b1);
    chk16("wait_wr.mem_addr", mem_addr, 16'h0040);
    chk16("wait_wr.mem_wdata", mem_wdata, 16'hBEEF);
    $display("deferred store 0040/BEEF acked after fill: ack=%b", d_wr_ack);
    d_wr = 1'b0;
    @(negedge clk);

    // Store and D miss together: store acked first, miss granted the next cycle.
    d_wr = 1'b1; d_wr_addr = 16'h2222; d_wr_data = 16'h1357;
    d_miss = 1'b1; d_addr = 16'h8884;
    #1;
    chk1("wr_vs_miss.ack", d_wr_ack, 1'b1);
    chk16("wr_vs_miss.addr", mem_addr, 16'h2222);
    chk1("wr_vs_miss.fill_sel", fill_sel, 1'b0);
    @(negedge clk);
    d_wr = 1'b0;
    #1 chk1("wr_vs_miss.grant_en", mem_en, 1'b0);
    expect_fill(1'b1, 16'h8880, -1, -1);
    @(negedge clk);

    // Reset in the middle of a fill; in-flight words must be dropped.
    i_miss = 1'b1; i_addr = 16'h3000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk16("prerst.mem_addr", mem_addr, 16'h3000 + 16'(2 * (k - 1)));
    end
    i_miss = 1'b0;
    rst = 1'b1;
    #1 chk_all_zero("rst_async");
    @(negedge clk);
    chk_all_zero("rst_edge");
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk1("stray.fill_we", fill_we, 1'b0);
      chk1("stray.tag_we", fill_tag_we, 1'b0);
      chk1("stray.i_done", i_done, 1'b0);
      chk1("stray.d_done", d_done, 1'b0);
      chk1("stray.mem_en", mem_en, 1'b0);
    end
    $display("reset mid-fill: stray words observed with no fill activity");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
